// File: rtl/ftm_cfg_seq.sv
// rtl/ftm_cfg_seq.sv - FlexTimer edge-aligned PWM bring-up sequencer
// Optional per-write readback verify: define FTM_CFG_READBACK_EN.
module ftm_cfg_seq #(
    parameter int NCH = 8,
    localparam int CW = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [15:0]       cfg_mod,
    input  logic [15:0]       cfg_cntin,
    input  logic [NCH-1:0]    cfg_ch_en,
    input  logic [7:0]        cfg_csc,
    input  logic [16*NCH-1:0] cfg_cnv,
    input  logic [1:0]        cfg_clks,
    input  logic [2:0]        cfg_ps,
    output logic              wr_en,
    output logic              rd_en,
    output logic [4:0]        reg_name,
    output logic [CW-1:0]     ch_sel,
    output logic [31:0]       wdata,
    input  logic [31:0]       rdata,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              err
);
    localparam logic [4:0] R_SC    = 5'd0;
    localparam logic [4:0] R_CNT   = 5'd1;
    localparam logic [4:0] R_MOD   = 5'd2;
    localparam logic [4:0] R_CSC   = 5'd3;
    localparam logic [4:0] R_CNV   = 5'd4;
    localparam logic [4:0] R_CNTIN = 5'd5;
    localparam logic [4:0] R_MODE  = 5'd7;

    // Channel scanning is combinational inside the W_CNT/W_CNV transitions,
    // so CH_SCAN never occupies a cycle and has no state of its own.
    typedef enum logic [3:0] {
        IDLE, W_MODE, W_STOP, W_CNTIN, W_MOD, W_CNT, W_CSC, W_CNV, W_SC,
        FIN, A_STOP, A_DONE, RD, RB_LAST
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       ch_q, ch_d;
    logic [15:0]         mod_q, mod_d, cntin_q, cntin_d;
    logic [NCH-1:0]      ch_en_q, ch_en_d;
    logic [7:0]          csc_q, csc_d;
    logic [16*NCH-1:0]   cnv_q, cnv_d;
    logic [1:0]          clks_q, clks_d;
    logic [2:0]          ps_q, ps_d;

    state_t              src, seq_next;
    logic [15:0]         val;
    logic [CW:0]         scan_from;
    logic                scan_hit;
    logic [CW-1:0]       scan_ch;
    logic                abort_ok;

`ifdef FTM_CFG_READBACK_EN
    state_t              wst_q, wst_d;
    logic                cmp_q, cmp_d, wide_q, wide_d, err_q, err_d;
    logic [15:0]         exp_q, exp_d;
    logic                mismatch;
`else
    logic                unused_rdata;
    assign unused_rdata = ^rdata;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            mod_q   <= '0;
            cntin_q <= '0;
            ch_en_q <= '0;
            csc_q   <= '0;
            cnv_q   <= '0;
            clks_q  <= '0;
            ps_q    <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            mod_q   <= mod_d;
            cntin_q <= cntin_d;
            ch_en_q <= ch_en_d;
            csc_q   <= csc_d;
            cnv_q   <= cnv_d;
            clks_q  <= clks_d;
            ps_q    <= ps_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        mod_d   = mod_q;
        cntin_d = cntin_q;
        ch_en_d = ch_en_q;
        csc_d   = csc_q;
        cnv_d   = cnv_q;
        clks_d  = clks_q;
        ps_d    = ps_q;

        // src is the write this bus cycle belongs to (a readback reuses it)
        src = state_q;
`ifdef FTM_CFG_READBACK_EN
        wst_d = wst_q;
        if (state_q == RD) src = wst_q;
`endif

        reg_name = 5'd0;
        ch_sel   = '0;
        val      = 16'h0000;
        case (src)
            W_MODE:  begin reg_name = R_MODE;  val = 16'h0005; end
            W_STOP:  reg_name = R_SC;
            W_CNTIN: begin reg_name = R_CNTIN; val = cntin_q; end
            W_MOD:   begin reg_name = R_MOD;   val = mod_q; end
            W_CNT:   reg_name = R_CNT;
            W_CSC:   begin reg_name = R_CSC; ch_sel = ch_q; val = {8'h00, csc_q}; end
            W_CNV:   begin reg_name = R_CNV; ch_sel = ch_q; val = cnv_q[{ch_q, 4'b0000} +: 16]; end
            W_SC:    begin reg_name = R_SC;    val = {11'd0, clks_q, ps_q}; end
            A_STOP:  reg_name = R_SC;
            default: reg_name = 5'd0;
        endcase

        scan_from = (src == W_CNT) ? '0 : ({1'b0, ch_q} + (CW+1)'(1));
        scan_hit  = 1'b0;
        scan_ch   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!scan_hit && ch_en_q[i] && ((CW+1)'(i) >= scan_from)) begin
                scan_hit = 1'b1;
                scan_ch  = CW'(i);
            end
        end

        case (src)
            W_MODE:       seq_next = W_STOP;
            W_STOP:       seq_next = W_CNTIN;
            W_CNTIN:      seq_next = W_MOD;
            W_MOD:        seq_next = W_CNT;
            W_CNT, W_CNV: seq_next = scan_hit ? W_CSC : W_SC;
            W_CSC:        seq_next = W_CNV;
`ifdef FTM_CFG_READBACK_EN
            W_SC:         seq_next = RB_LAST;
`else
            W_SC:         seq_next = FIN;
`endif
            default:      seq_next = IDLE;
        endcase

        // once the final SC write is on the bus, completion beats abort
        abort_ok = abort && (src != W_SC);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = W_MODE;
                    ch_d    = '0;
                    mod_d   = cfg_mod;
                    cntin_d = cfg_cntin;
                    ch_en_d = cfg_ch_en;
                    csc_d   = cfg_csc;
                    cnv_d   = cfg_cnv;
                    clks_d  = cfg_clks;
                    ps_d    = cfg_ps;
                end
            end
            FIN, A_DONE: state_d = IDLE;
            A_STOP:      state_d = A_DONE;
            RB_LAST:     state_d = FIN;
            default: begin
                if (abort_ok) begin
                    state_d = A_STOP;
                end else begin
`ifdef FTM_CFG_READBACK_EN
                    if (state_q != RD && state_q != W_CNT) begin
                        state_d = RD;
                        wst_d   = state_q;
                    end else begin
                        state_d = seq_next;
                        if (seq_next == W_CSC) ch_d = scan_ch;
                    end
`else
                    state_d = seq_next;
                    if (seq_next == W_CSC) ch_d = scan_ch;
`endif
                end
            end
        endcase
    end

    assign wr_en   = state_q inside {W_MODE, W_STOP, W_CNTIN, W_MOD, W_CNT,
                                     W_CSC, W_CNV, W_SC, A_STOP};
    assign wdata   = wr_en ? {16'h0000, val} : 32'h0000_0000;
    assign busy    = !(state_q inside {IDLE, FIN, A_DONE});
    assign done    = (state_q == FIN);
    assign aborted = (state_q == A_DONE);

`ifdef FTM_CFG_READBACK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wst_q  <= IDLE;
            cmp_q  <= 1'b0;
            wide_q <= 1'b0;
            exp_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            wst_q  <= wst_d;
            cmp_q  <= cmp_d;
            wide_q <= wide_d;
            exp_q  <= exp_d;
            err_q  <= err_d;
        end
    end

    // rdata for a read arrives the following cycle, overlapping the next write
    always_comb begin
        cmp_d    = (state_q == RD);
        exp_d    = val;
        wide_d   = src inside {W_CNTIN, W_MOD, W_CNV};
        mismatch = wide_q ? (rdata[15:0] != exp_q) : (rdata[7:0] != exp_q[7:0]);
        err_d    = err_q;
        if (state_q == IDLE && start) err_d = 1'b0;
        if (cmp_q && mismatch)        err_d = 1'b1;
    end

    assign rd_en = (state_q == RD);
    assign err   = err_q;
`else
    assign rd_en = 1'b0;
    assign err   = 1'b0;
`endif
endmodule

// File: tb/tb_ftm_cfg_seq.sv
// tb/tb_ftm_cfg_seq.sv - directed vector bench for ftm_cfg_seq
module tb_ftm_cfg_seq;
    localparam logic [4:0] R_SC = 5'd0, R_CNT = 5'd1, R_MOD = 5'd2, R_CSC = 5'd3,
                           R_CNV = 5'd4, R_CNTIN = 5'd5, R_MODE = 5'd7;

    logic         clk = 1'b0;
    logic         rst, start, abort;
    logic [15:0]  cfg_mod, cfg_cntin;
    logic [7:0]   cfg_ch_en, cfg_csc;
    logic [127:0] cfg_cnv;
    logic [1:0]   cfg_clks;
    logic [2:0]   cfg_ps;
    logic         wr_en, rd_en, busy, done, aborted, err;
    logic [4:0]   reg_name;
    logic [2:0]   ch_sel;
    logic [31:0]  wdata;
    logic [31:0]  rdata = 32'h0;

    always #5 clk = ~clk;

    ftm_cfg_seq #(.NCH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_mod(cfg_mod), .cfg_cntin(cfg_cntin), .cfg_ch_en(cfg_ch_en),
        .cfg_csc(cfg_csc), .cfg_cnv(cfg_cnv), .cfg_clks(cfg_clks), .cfg_ps(cfg_ps),
        .wr_en(wr_en), .rd_en(rd_en), .reg_name(reg_name), .ch_sel(ch_sel),
        .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
        .aborted(aborted), .err(err)
    );

    // register file behind the bus; optionally corrupts MOD reads
    logic [31:0] mem [0:7][0:7];
    logic        bad_mod = 1'b0;
    always @(posedge clk) begin
        if (wr_en) mem[reg_name[2:0]][ch_sel] <= wdata;
        if (rd_en) rdata <= (bad_mod && reg_name == R_MOD) ? 32'h0000_00FE
                                                           : mem[reg_name[2:0]][ch_sel];
    end

    typedef struct {
        logic [7:0]   ch_en;
        logic [15:0]  mod;
        logic [15:0]  cntin;
        logic [7:0]   csc;
        logic [127:0] cnv;
        logic [1:0]   clks;
        logic [2:0]   ps;
        int           exp_w;
        int           exp_done;
        logic [31:0]  exp_sc;
    } vec_t;
    vec_t vecs [4];

    int passed = 0, total = 0;

    logic [4:0]  c_reg [64];
    logic [2:0]  c_ch [64];
    logic [31:0] c_data [64];
    int          c_rel [64];
    logic        err_tr [64];
    int nw, nr, done_rel, ab_rel, n_done, both;
    logic busy_done, busy_ab, err_done;

    logic [4:0]  e_reg [64];
    logic [2:0]  e_ch [64];
    logic [31:0] e_data [64];
    int ne;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic set_cfg(input vec_t v);
        cfg_ch_en = v.ch_en; cfg_mod = v.mod; cfg_cntin = v.cntin; cfg_csc = v.csc;
        cfg_cnv = v.cnv; cfg_clks = v.clks; cfg_ps = v.ps;
    endtask

    task automatic push(input logic [4:0] r, input logic [2:0] c, input logic [31:0] d);
        e_reg[ne] = r; e_ch[ne] = c; e_data[ne] = d; ne++;
    endtask

    task automatic build_exp(input vec_t v);
        ne = 0;
        push(R_MODE, 3'd0, 32'h5);
        push(R_SC, 3'd0, 32'h0);
        push(R_CNTIN, 3'd0, {16'h0, v.cntin});
        push(R_MOD, 3'd0, {16'h0, v.mod});
        push(R_CNT, 3'd0, 32'h0);
        for (int n = 0; n < 8; n++) begin
            if (v.ch_en[n]) begin
                push(R_CSC, 3'(n), {24'h0, v.csc});
                push(R_CNV, 3'(n), {16'h0, v.cnv[16*n +: 16]});
            end
        end
        push(R_SC, 3'd0, {27'h0, v.clks, v.ps});
    endtask

    // pulse start, then observe a fixed window of cycles; rel 1 is the cycle after start is sampled
    task automatic run_seq(input int budget, input int abort_rel, input int restart_rel);
        nw = 0; nr = 0; done_rel = -1; ab_rel = -1; n_done = 0; both = 0;
        busy_done = 1'bx; busy_ab = 1'bx; err_done = 1'bx;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int rel = 1; rel <= budget; rel++) begin
            @(negedge clk);
            if (rel < 64) err_tr[rel] = err;
            if (wr_en && rd_en) both++;
            if (wr_en && nw < 64) begin
                c_reg[nw] = reg_name; c_ch[nw] = ch_sel; c_data[nw] = wdata; c_rel[nw] = rel;
                nw++;
            end
            if (rd_en) nr++;
            if (done) begin
                n_done++;
                if (done_rel < 0) begin done_rel = rel; busy_done = busy; err_done = err; end
            end
            if (aborted && ab_rel < 0) begin ab_rel = rel; busy_ab = busy; end
            abort = (rel == abort_rel);
            start = (rel == restart_rel);
            if (rel == 2) begin cfg_mod = 16'hDEAD; cfg_ch_en = ~cfg_ch_en; cfg_ps = ~cfg_ps; end
        end
        abort = 1'b0; start = 1'b0;
    endtask

    task automatic chk_stream(input string tag);
        for (int j = 0; j < ne; j++) begin
            chk($sformatf("%s_w%0d", tag, j), {c_reg[j], c_ch[j], c_data[j]},
                {e_reg[j], e_ch[j], e_data[j]});
            chk($sformatf("%s_rel%0d", tag, j), c_rel[j], j + 1);
        end
    endtask

    initial begin
        vecs[0] = '{ch_en:8'h00, mod:16'h00FF, cntin:16'h0010, csc:8'h00, cnv:128'h0,
                    clks:2'd1, ps:3'd3, exp_w:6, exp_done:7, exp_sc:32'h0B};
        vecs[1] = '{ch_en:8'h81, mod:16'h00FF, cntin:16'h0010, csc:8'h28,
                    cnv:128'h0080_0000_0000_0000_0000_0000_0000_0040,
                    clks:2'd1, ps:3'd3, exp_w:10, exp_done:11, exp_sc:32'h0B};
        vecs[2] = '{ch_en:8'hFF, mod:16'h1234, cntin:16'h0000, csc:8'h68,
                    cnv:128'h7007_6006_5005_4004_3003_2002_1001_0F00,
                    clks:2'd2, ps:3'd7, exp_w:22, exp_done:23, exp_sc:32'h17};
        vecs[3] = '{ch_en:8'h24, mod:16'h8000, cntin:16'h7FFF, csc:8'hA8,
                    cnv:128'h0000_0000_BEEF_0000_0000_CAFE_0000_0000,
                    clks:2'd3, ps:3'd0, exp_w:10, exp_done:11, exp_sc:32'h18};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        set_cfg(vecs[0]);
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", {wr_en, rd_en, reg_name, ch_sel, wdata, busy, done, aborted, err}, 0);
        @(posedge clk); #1 rst = 1'b0;

`ifndef FTM_CFG_READBACK_EN
        for (int i = 0; i < 4; i++) begin
            set_cfg(vecs[i]);
            run_seq(40, -1, -1);
            build_exp(vecs[i]);
            chk($sformatf("v%0d_nwrites", i), nw, vecs[i].exp_w);
            chk($sformatf("v%0d_done_cycle", i), done_rel, vecs[i].exp_done);
            chk($sformatf("v%0d_done_count", i), n_done, 1);
            chk($sformatf("v%0d_busy_at_done", i), busy_done, 0);
            chk($sformatf("v%0d_final_sc", i), (nw > 0) ? c_data[nw-1] : 32'hFFFF_FFFF, vecs[i].exp_sc);
            chk($sformatf("v%0d_no_reads", i), nr + both, 0);
            chk_stream($sformatf("v%0d", i));
        end

        set_cfg(vecs[1]);
        run_seq(40, -1, 3);
        build_exp(vecs[1]);
        chk("restart_nwrites", nw, 10);
        chk("restart_done_count", n_done, 1);
        chk("restart_done_cycle", done_rel, 11);
        chk_stream("restart");

        set_cfg(vecs[1]);
        run_seq(20, 6, -1);
        chk("abort_nwrites", nw, 7);
        chk("abort_cur_write", {c_reg[5], c_ch[5]}, {R_CSC, 3'd0});
        chk("abort_stop_write", {c_reg[6], c_data[6]}, {R_SC, 32'h0});
        chk("abort_stop_cycle", c_rel[6], 7);
        chk("abort_pulse_cycle", ab_rel, 8);
        chk("abort_busy", busy_ab, 0);
        chk("abort_no_done", n_done, 0);

        set_cfg(vecs[0]);
        run_seq(20, 6, -1);
        chk("late_abort_done_cycle", done_rel, 7);
        chk("late_abort_no_aborted", ab_rel, -1);
        chk("late_abort_nwrites", nw, 6);

        set_cfg(vecs[1]);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_scan_pre", {wr_en, reg_name, busy}, {1'b1, R_CNV, 1'b1});
        #2 rst = 1'b1;
        #1 chk("mid_reset_outputs", {wr_en, rd_en, reg_name, ch_sel, wdata, busy, done, aborted, err}, 0);
        @(posedge clk); #1 rst = 1'b0;
        set_cfg(vecs[1]);
        run_seq(30, -1, -1);
        chk("replay_first", {c_reg[0], c_data[0]}, {R_MODE, 32'h5});
        chk("replay_nwrites", nw, 10);
        chk("replay_done_cycle", done_rel, 11);
`else
        bad_mod = 1'b1;
        set_cfg(vecs[0]);
        run_seq(30, -1, -1);
        chk("rb_nwrites", nw, 6);
        chk("rb_nreads", nr, 5);
        chk("rb_never_both", both, 0);
        chk("rb_err_before_mod_cmp", err_tr[9], 0);
        chk("rb_err_after_mod_cmp", err_tr[10], 1);
        chk("rb_done_cycle", done_rel, 13);
        chk("rb_err_at_done", err_done, 1);
        bad_mod = 1'b0;
        set_cfg(vecs[1]);
        run_seq(40, -1, -1);
        chk("rb_err_cleared", err_tr[1], 0);
        chk("rb2_nwrites", nw, 10);
        chk("rb2_nreads", nr, 9);
        chk("rb2_done_cycle", done_rel, 21);
        chk("rb2_err_at_done", err_done, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
